key_event_sched: RTL and testbench

//   Sequences up to NUM_KEYS debounced keys (key_flag/key_value pairs from the per-key debouncers).
//   Per-key FSM classifies each key's activity into events: PRESS, RELEASE, LONG, REPEAT.
//   A round-robin arbiter serialises the events onto one valid/ready stream for the UI/CPU side.

---
 rtl/key_event_sched_if.sv | 33 +++
 rtl/key_event_sched.sv | 181 ++++++++++++++++++
 tb/tb_key_event_sched.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_event_sched_if.sv
// Event stream between the key scheduler and its UI/CPU consumer.
//   evt_valid  scheduler -> consumer  event available
//   evt_ready  consumer -> scheduler  transfer when evt_valid && evt_ready
//   evt_key    scheduler -> consumer  key index of the event
//   evt_type   scheduler -> consumer  0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT
//   evt_ovf    scheduler -> consumer  1-cycle pulse, a pending event was overwritten
interface key_event_sched_if #(
  parameter int NUM_KEYS = 4
);
  localparam int ID_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_key;
  logic [1:0]      evt_type;
  logic            evt_ovf;

  modport master (
    output evt_valid,
    output evt_key,
    output evt_type,
    output evt_ovf,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_key,
    input  evt_type,
    input  evt_ovf,
    output evt_ready
  );
endinterface

// File: rtl/key_event_sched.sv
// Key event scheduler: classifies debounced key activity into PRESS / RELEASE /
// LONG / REPEAT events per key and serialises them onto one valid/ready stream
// through a round-robin arbiter.
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst    asynchronous reset, active-high
//   key_flag   per-key 1-cycle strobe: key_value[i] is newly stable
//   key_value  per-key debounced level, 0 = pressed, 1 = released
//   evt        event stream (master side of key_event_sched_if)
//
// Per-key FSM
//   state      | meaning
//   ST_IDLE    | key released, counter parked at 0
//   ST_PRESSED | key down, counting towards LONG
//   ST_LONG    | LONG posted, counting towards each REPEAT (if enabled)
module key_event_sched #(
  parameter int NUM_KEYS   = 4,
  parameter int CNT_W      = 32,
  parameter int LONG_CNT   = 50_000_000,
  parameter int REPEAT_CNT = 10_000_000
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key_flag,
  input  logic [NUM_KEYS-1:0] key_value,
  key_event_sched_if.master   evt
);
  localparam int ID_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_RELEASE = 2'd1;
  localparam logic [1:0] EVT_LONG    = 2'd2;
  localparam logic [1:0] EVT_REPEAT  = 2'd3;

  // Hold timers run downwards from interval-1; terminal count is zero.
  localparam logic [CNT_W-1:0] LONG_LD   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_LD = (REPEAT_CNT > 0) ? CNT_W'(REPEAT_CNT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } key_st_e;

  key_st_e             state_q   [NUM_KEYS];
  key_st_e             state_d   [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_q     [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d     [NUM_KEYS];
  logic [NUM_KEYS-1:0] post;
  logic [1:0]          post_type [NUM_KEYS];

  logic [NUM_KEYS-1:0] pend_q;
  logic [1:0]          ptype_q   [NUM_KEYS];
  logic [ID_W-1:0]     rr_q;
  logic [ID_W-1:0]     win;
  logic                found;
  logic                load;
  logic [NUM_KEYS-1:0] grant;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      post[i]      = 1'b0;
      post_type[i] = EVT_PRESS;
      case (state_q[i])
        ST_IDLE: begin
          cnt_d[i] = '0;
          if (key_flag[i] && !key_value[i]) begin
            post[i]    = 1'b1;
            cnt_d[i]   = LONG_LD;
            state_d[i] = ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          // Release outranks a terminal count landing in the same cycle.
          if (key_flag[i] && key_value[i]) begin
            post[i]      = 1'b1;
            post_type[i] = EVT_RELEASE;
            cnt_d[i]     = '0;
            state_d[i]   = ST_IDLE;
          end else if (cnt_q[i] == '0) begin
            post[i]      = 1'b1;
            post_type[i] = EVT_LONG;
            cnt_d[i]     = REPEAT_LD;
            state_d[i]   = ST_LONG;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        ST_LONG: begin
          if (key_flag[i] && key_value[i]) begin
            post[i]      = 1'b1;
            post_type[i] = EVT_RELEASE;
            cnt_d[i]     = '0;
            state_d[i]   = ST_IDLE;
          end else if (REPEAT_CNT == 0) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == '0) begin
            post[i]      = 1'b1;
            post_type[i] = EVT_REPEAT;
            cnt_d[i]     = REPEAT_LD;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Round-robin pick: first pending key at or above the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    grant = '0;
    for (int off = 0; off < NUM_KEYS; off++) begin
      if (!found && pend_q[ID_W'((int'(rr_q) + off) % NUM_KEYS)]) begin
        found = 1'b1;
        win   = ID_W'((int'(rr_q) + off) % NUM_KEYS);
      end
    end
    load = !evt.evt_valid || evt.evt_ready;
    if (load && found) begin
      grant[win] = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pend_q        <= '0;
      rr_q          <= '0;
      evt.evt_valid <= 1'b0;
      evt.evt_key   <= '0;
      evt.evt_type  <= '0;
      evt.evt_ovf   <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        ptype_q[i] <= '0;
      end
    end else begin
      // A post always wins the slot; when it coincides with a grant the old
      // type has already been taken, so the new one simply stays pending.
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (post[i]) begin
          pend_q[i]  <= 1'b1;
          ptype_q[i] <= post_type[i];
        end else if (grant[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
      evt.evt_ovf <= |(post & pend_q & ~grant);
      if (load) begin
        if (found) begin
          evt.evt_valid <= 1'b1;
          evt.evt_key   <= win;
          evt.evt_type  <= ptype_q[win];
          rr_q          <= ID_W'((int'(win) + 1) % NUM_KEYS);
        end else begin
          evt.evt_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_key_event_sched.sv
// Bench for key_event_sched: directed scenarios plus a randomized phase, all
// checked cycle by cycle against a reference model built from hold ages and a
// per-key pending slot.
module tb_key_event_sched;
  localparam int NUM_KEYS   = 4;
  localparam int CNT_W      = 16;
  localparam int LONG_CNT   = 20;
  localparam int REPEAT_CNT = 5;

  logic                sys_clk = 1'b0;
  logic                sys_rst;
  logic [NUM_KEYS-1:0] key_flag;
  logic [NUM_KEYS-1:0] key_value;

  key_event_sched_if #(.NUM_KEYS(NUM_KEYS)) ev ();

  key_event_sched #(
    .NUM_KEYS  (NUM_KEYS),
    .CNT_W     (CNT_W),
    .LONG_CNT  (LONG_CNT),
    .REPEAT_CNT(REPEAT_CNT)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .key_flag (key_flag),
    .key_value(key_value),
    .evt      (ev)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  int   cyc;
  bit   m_held  [NUM_KEYS];
  int   m_tp    [NUM_KEYS];
  bit   m_pend  [NUM_KEYS];
  int   m_ptype [NUM_KEYS];
  bit   m_valid;
  int   m_key;
  int   m_type;
  bit   m_ovf;
  int   m_rr;

  task automatic model_reset();
    for (int i = 0; i < NUM_KEYS; i++) begin
      m_held[i] = 0; m_tp[i] = 0; m_pend[i] = 0; m_ptype[i] = 0;
    end
    m_valid = 0; m_key = 0; m_type = 0; m_ovf = 0; m_rr = 0;
  endtask

  task automatic model_edge();
    int  w;
    int  age;
    bit  post;
    int  pt;
    bit  ovf;
    cyc++;
    if (sys_rst) begin
      model_reset();
      return;
    end
    w = -1;
    if (!m_valid || ev.evt_ready) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        int j;
        j = (m_rr + k) % NUM_KEYS;
        if (w < 0 && m_pend[j]) w = j;
      end
      if (w >= 0) begin
        m_valid = 1; m_key = w; m_type = m_ptype[w]; m_rr = (w + 1) % NUM_KEYS;
      end else begin
        m_valid = 0;
      end
    end
    ovf = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      post = 0; pt = 0;
      if (!m_held[i]) begin
        if (key_flag[i] && !key_value[i]) begin
          post = 1; pt = 0; m_held[i] = 1; m_tp[i] = cyc;
        end
      end else if (key_flag[i] && key_value[i]) begin
        post = 1; pt = 1; m_held[i] = 0;
      end else begin
        age = cyc - m_tp[i];
        if (age == LONG_CNT) begin
          post = 1; pt = 2;
        end else if (REPEAT_CNT != 0 && age > LONG_CNT && (age - LONG_CNT) % REPEAT_CNT == 0) begin
          post = 1; pt = 3;
        end
      end
      if (post) begin
        if (m_pend[i] && w != i) ovf = 1;
        m_pend[i] = 1; m_ptype[i] = pt;
      end else if (w == i) begin
        m_pend[i] = 0;
      end
    end
    m_ovf = ovf;
  endtask

  // transfers observed on the stream, for directed sequence checks
  int lg_key[$];
  int lg_type[$];
  int exp_k[$];
  int exp_t[$];

  task automatic expect_evt(input int k, input int t);
    exp_k.push_back(k);
    exp_t.push_back(t);
  endtask

  task automatic check_log(input string tag);
    check_val({tag, "_count"}, 32'(lg_key.size()), 32'(exp_k.size()));
    for (int i = 0; i < exp_k.size() && i < lg_key.size(); i++) begin
      check_val({tag, "_key"}, 32'(lg_key[i]), 32'(exp_k[i]));
      check_val({tag, "_type"}, 32'(lg_type[i]), 32'(exp_t[i]));
    end
    lg_key.delete(); lg_type.delete(); exp_k.delete(); exp_t.delete();
  endtask

  task automatic tick();
    if (ev.evt_valid === 1'b1 && ev.evt_ready === 1'b1) begin
      lg_key.push_back(int'(ev.evt_key));
      lg_type.push_back(int'(ev.evt_type));
    end
    @(posedge sys_clk);
    model_edge();
    #1;
    check_val("valid", 32'(ev.evt_valid), 32'(m_valid));
    if (m_valid) begin
      check_val("key", 32'(ev.evt_key), 32'(m_key));
      check_val("type", 32'(ev.evt_type), 32'(m_type));
    end
    check_val("ovf", 32'(ev.evt_ovf), 32'(m_ovf));
    key_flag = '0;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_valid"}, 32'(ev.evt_valid), 32'd0);
    check_val({tag, "_key"}, 32'(ev.evt_key), 32'd0);
    check_val({tag, "_type"}, 32'(ev.evt_type), 32'd0);
    check_val({tag, "_ovf"}, 32'(ev.evt_ovf), 32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    sys_rst = 1'b1;
    #1;
    model_reset();
    check_zero(tag);
    key_value = '1;
    tick();
    sys_rst = 1'b0;
    lg_key.delete(); lg_type.delete();
  endtask

  task automatic flag_keys(input logic [NUM_KEYS-1:0] mask, input logic level);
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (mask[i]) begin
        key_flag[i]  = 1'b1;
        key_value[i] = level;
      end
    end
  endtask

  int ovf_seen;

  initial begin
    cyc          = 0;
    sys_rst      = 1'b1;
    key_flag     = '0;
    key_value    = '1;
    ev.evt_ready = 1'b0;
    model_reset();
    #2;
    check_zero("reset");
    #10;
    sys_rst = 1'b0;

    // single press, two-edge latency, one-cycle valid
    ev.evt_ready = 1'b1;
    flag_keys(4'b0100, 1'b0);
    tick();
    check_val("s1_early", 32'(ev.evt_valid), 32'd0);
    tick();
    check_val("s1_valid", 32'(ev.evt_valid), 32'd1);
    check_val("s1_key", 32'(ev.evt_key), 32'd2);
    check_val("s1_type", 32'(ev.evt_type), 32'd0);
    tick();
    check_val("s1_drop", 32'(ev.evt_valid), 32'd0);
    flag_keys(4'b0100, 1'b1);
    tick();
    repeat (3) tick();
    lg_key.delete(); lg_type.delete();

    // long hold with repeats
    flag_keys(4'b0001, 1'b0);
    tick();
    repeat (30) tick();
    flag_keys(4'b0001, 1'b1);
    tick();
    repeat (3) tick();
    expect_evt(0, 0); expect_evt(0, 2); expect_evt(0, 3); expect_evt(0, 3); expect_evt(0, 1);
    check_log("s2");

    // simultaneous bursts, round-robin order from pointer 0
    pulse_reset("s3_rst");
    flag_keys(4'b1011, 1'b0);
    tick();
    repeat (4) tick();
    flag_keys(4'b1011, 1'b1);
    tick();
    repeat (4) tick();
    expect_evt(0, 0); expect_evt(1, 0); expect_evt(3, 0);
    expect_evt(0, 1); expect_evt(1, 1); expect_evt(3, 1);
    check_log("s3");

    // back-pressure: stable payload, overwrite while stalled
    ev.evt_ready = 1'b0;
    flag_keys(4'b0100, 1'b0);
    tick();
    tick();
    ovf_seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) flag_keys(4'b0010, 1'b0);
      if (c == 4) flag_keys(4'b0010, 1'b1);
      tick();
      if (ev.evt_ovf === 1'b1) ovf_seen++;
      check_val("s4_hold_valid", 32'(ev.evt_valid), 32'd1);
      check_val("s4_hold_key", 32'(ev.evt_key), 32'd2);
      check_val("s4_hold_type", 32'(ev.evt_type), 32'd0);
    end
    check_val("s4_ovf_pulses", 32'(ovf_seen), 32'd1);
    lg_key.delete(); lg_type.delete();
    ev.evt_ready = 1'b1;
    repeat (3) tick();
    expect_evt(2, 0); expect_evt(1, 1);
    check_log("s4");
    flag_keys(4'b0100, 1'b1);
    tick();
    repeat (3) tick();
    lg_key.delete(); lg_type.delete();

    // release on the LONG terminal count, then a clean full-length hold
    flag_keys(4'b0001, 1'b0);
    tick();
    repeat (19) tick();
    flag_keys(4'b0001, 1'b1);
    tick();
    repeat (3) tick();
    flag_keys(4'b0001, 1'b0);
    tick();
    repeat (20) tick();
    flag_keys(4'b0001, 1'b1);
    tick();
    repeat (3) tick();
    expect_evt(0, 0); expect_evt(0, 1);
    expect_evt(0, 0); expect_evt(0, 2); expect_evt(0, 1);
    check_log("s5");

    // reset while an event is valid and others pending
    ev.evt_ready = 1'b0;
    flag_keys(4'b0111, 1'b0);
    tick();
    tick();
    check_val("s6_pre_valid", 32'(ev.evt_valid), 32'd1);
    pulse_reset("s6_rst");
    ev.evt_ready = 1'b1;
    repeat (10) tick();
    check_log("s6");

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if ($urandom_range(15) == 0) begin
          key_flag[i]  = 1'b1;
          key_value[i] = 1'($urandom_range(1));
        end
      end
      ev.evt_ready = ($urandom_range(3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
